// File: rtl/drum_pkg.sv
// Shared types and default constants for the drum strike detector.
package drum_pkg;

  // Detector FSM encoding; the numeric values are visible on state_dbg.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SWING   = 2'd1,
    ST_REFRACT = 2'd2,
    ST_SETTLE  = 2'd3
  } state_t;

  // Stick orientation zones, ordered from most negative to most positive quat_z.
  typedef enum logic [1:0] {
    ZONE_NEG_FAR  = 2'd0,
    ZONE_NEG_NEAR = 2'd1,
    ZONE_POS_NEAR = 2'd2,
    ZONE_POS_FAR  = 2'd3
  } zone_t;

  localparam int DEF_SWING_THRESH      = 4000;
  localparam int DEF_STOP_THRESH       = 1000;
  localparam int DEF_MAX_SWING_SAMPLES = 64;
  localparam int DEF_REFRACT_CYCLES    = 150000;
  localparam int DEF_ZONE_T            = 8192;

  // Absolute value of a signed rate as 15-bit unsigned; -32768 saturates to 32767.
  function automatic logic [14:0] gyro_mag(input logic signed [15:0] v);
    logic signed [15:0] neg;
    neg = -v;
    if (v == 16'sh8000) return 15'h7FFF;
    else if (v[15])     return neg[14:0];
    else                return v[14:0];
  endfunction

endpackage

// File: rtl/strike_zone_classifier.sv
// Combinational mapping of the registered quat_z onto one of four strike zones.
module strike_zone_classifier
  import drum_pkg::*;
#(
  parameter int ZONE_T = DEF_ZONE_T
) (
  input  logic signed [15:0] i_qz,
  output zone_t              o_zone
);

  logic signed [31:0] w_qz;

  assign w_qz = 32'(i_qz);

  // Threshold compare in 32-bit signed so ZONE_T can be any int.
  always_comb begin
    // NOTE: assign a default first so every path drives o_zone and no latch is inferred.
    o_zone = ZONE_POS_NEAR;
    if (w_qz < -ZONE_T)   o_zone = ZONE_NEG_FAR;
    else if (w_qz < 0)    o_zone = ZONE_NEG_NEAR;
    else if (w_qz < ZONE_T) o_zone = ZONE_POS_NEAR;
    else                  o_zone = ZONE_POS_FAR;
  end

endmodule

// File: rtl/drum_strike_detector.sv
// Detects downward drumstick swings from gyro_y, reports strike velocity and
// zone, then locks out for a refractory period before re-arming.
module drum_strike_detector
  import drum_pkg::*;
#(
  parameter int SWING_THRESH      = DEF_SWING_THRESH,
  parameter int STOP_THRESH       = DEF_STOP_THRESH,
  parameter int MAX_SWING_SAMPLES = DEF_MAX_SWING_SAMPLES,
  parameter int REFRACT_CYCLES    = DEF_REFRACT_CYCLES,
  parameter int ZONE_T            = DEF_ZONE_T
) (
  input  logic               clk,
  input  logic               fpga_rst_n,
  input  logic               enable,
  input  logic               gyro_valid,
  input  logic signed [15:0] gyro_x,
  input  logic signed [15:0] gyro_y,
  input  logic signed [15:0] gyro_z,
  input  logic               quat_valid,
  input  logic signed [15:0] quat_w,
  input  logic signed [15:0] quat_x,
  input  logic signed [15:0] quat_y,
  input  logic signed [15:0] quat_z,
  output logic               strike_valid,
  output logic [1:0]         strike_zone,
  output logic [7:0]         strike_velocity,
  output logic [15:0]        strike_count,
  output logic               swing_abort,
  output logic [1:0]         state_dbg
);

  localparam int CNT_W = $clog2(MAX_SWING_SAMPLES + 1);
  localparam int REF_W = $clog2(REFRACT_CYCLES + 1);

  localparam logic [14:0]      L_SWING    = 15'(SWING_THRESH);
  localparam logic [14:0]      L_STOP     = 15'(STOP_THRESH);
  localparam logic [CNT_W-1:0] L_MAX_SAMP = CNT_W'(MAX_SWING_SAMPLES);
  localparam logic [REF_W-1:0] L_REF_LAST = REF_W'(REFRACT_CYCLES - 1);

  state_t             r_state;
  logic [14:0]        r_peak;
  logic [CNT_W-1:0]   r_samples;
  logic [REF_W-1:0]   r_refract;
  logic signed [15:0] r_qz;
  logic               r_strike_valid;
  logic               r_swing_abort;
  zone_t              r_strike_zone;
  logic [7:0]         r_strike_velocity;
  logic [15:0]        r_strike_count;

  logic [14:0]        w_mag;
  logic [CNT_W-1:0]   w_samples_next;
  zone_t              w_zone;
  logic               w_unused;

  assign w_mag          = gyro_mag(gyro_y);
  assign w_samples_next = r_samples + 1'b1;

  // Only gyro_y and quat_z drive detection; the other axes are accepted but unused.
  assign w_unused = ^{gyro_x, gyro_z, quat_w, quat_x, quat_y};

  // Zone is taken from the quat_z held before this cycle's edge, so a quat
  // update coinciding with the deciding sample lands after the strike.
  strike_zone_classifier #(
    .ZONE_T (ZONE_T)
  ) u_zone (
    .i_qz   (r_qz),
    .o_zone (w_zone)
  );

  // Latch the most recent orientation sample; reads as zero until the first one.
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!fpga_rst_n)     r_qz <= '0;
    else if (quat_valid) r_qz <= quat_z;
  end

  // Detector FSM with registered strike/abort outputs.
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      r_state           <= ST_IDLE;
      r_peak            <= '0;
      r_samples         <= '0;
      r_refract         <= '0;
      r_strike_valid    <= 1'b0;
      r_swing_abort     <= 1'b0;
      r_strike_zone     <= ZONE_NEG_FAR;
      r_strike_velocity <= '0;
      r_strike_count    <= '0;
    end else begin
      r_strike_valid <= 1'b0;
      r_swing_abort  <= 1'b0;
      if (!enable) begin
        r_state   <= ST_IDLE;
        r_samples <= '0;
        r_refract <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (gyro_valid && gyro_y[15] && (w_mag >= L_SWING)) begin
              r_state   <= ST_SWING;
              r_peak    <= w_mag;
              r_samples <= CNT_W'(1);
            end
          end
          ST_SWING: begin
            if (gyro_valid) begin
              if (w_mag < L_STOP) begin
                r_state           <= ST_REFRACT;
                r_refract         <= '0;
                r_strike_valid    <= 1'b1;
                r_strike_velocity <= r_peak[14:7];
                r_strike_zone     <= w_zone;
                r_strike_count    <= r_strike_count + 16'd1;
              end else begin
                if (w_mag > r_peak) r_peak <= w_mag;
                r_samples <= w_samples_next;
                if (w_samples_next >= L_MAX_SAMP) begin
                  r_state       <= ST_SETTLE;
                  r_swing_abort <= 1'b1;
                end
              end
            end
          end
          ST_REFRACT: begin
            if (r_refract == L_REF_LAST) r_state <= ST_SETTLE;
            else                         r_refract <= r_refract + 1'b1;
          end
          ST_SETTLE: begin
            if (gyro_valid && (w_mag < L_STOP)) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign strike_valid    = r_strike_valid;
  assign swing_abort     = r_swing_abort;
  assign strike_zone     = r_strike_zone;
  assign strike_velocity = r_strike_velocity;
  assign strike_count    = r_strike_count;
  assign state_dbg       = r_state;

endmodule

// File: tb/tb_drum_strike_detector.sv
// Directed self-checking bench for drum_strike_detector. The refractory period
// is shortened so several complete strike cycles fit in a short run.
module tb_drum_strike_detector;

  localparam int REFRACT = 2000;

  logic               clk = 1'b0;
  logic               fpga_rst_n = 1'b0;
  logic               enable = 1'b0;
  logic               gyro_valid = 1'b0;
  logic signed [15:0] gyro_x = '0;
  logic signed [15:0] gyro_y = '0;
  logic signed [15:0] gyro_z = '0;
  logic               quat_valid = 1'b0;
  logic signed [15:0] quat_w = '0;
  logic signed [15:0] quat_x = '0;
  logic signed [15:0] quat_y = '0;
  logic signed [15:0] quat_z = '0;
  logic               strike_valid;
  logic [1:0]         strike_zone;
  logic [7:0]         strike_velocity;
  logic [15:0]        strike_count;
  logic               swing_abort;
  logic [1:0]         state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int n_sv     = 0;
  int n_ab     = 0;
  int n_overlap = 0;

  always #5 clk = ~clk;

  drum_strike_detector #(
    .REFRACT_CYCLES (REFRACT)
  ) dut (
    .clk             (clk),
    .fpga_rst_n      (fpga_rst_n),
    .enable          (enable),
    .gyro_valid      (gyro_valid),
    .gyro_x          (gyro_x),
    .gyro_y          (gyro_y),
    .gyro_z          (gyro_z),
    .quat_valid      (quat_valid),
    .quat_w          (quat_w),
    .quat_x          (quat_x),
    .quat_y          (quat_y),
    .quat_z          (quat_z),
    .strike_valid    (strike_valid),
    .strike_zone     (strike_zone),
    .strike_velocity (strike_velocity),
    .strike_count    (strike_count),
    .swing_abort     (swing_abort),
    .state_dbg       (state_dbg)
  );

  // Pulse counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (strike_valid === 1'b1) n_sv++;
    if (swing_abort === 1'b1)  n_ab++;
    if (strike_valid === 1'b1 && swing_abort === 1'b1) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gyro(input logic signed [15:0] y);
    gyro_y = y;
    gyro_valid = 1'b1;
    @(negedge clk);
    gyro_valid = 1'b0;
    gyro_y = '0;
  endtask

  task automatic quat(input logic signed [15:0] z);
    quat_z = z;
    quat_valid = 1'b1;
    @(negedge clk);
    quat_valid = 1'b0;
  endtask

  // Called on the falling edge right after the deciding sample.
  task automatic strike_check(input string tag, input int vel, input int zone, input int cnt);
    check({tag, "_valid"}, strike_valid, 1);
    check({tag, "_vel"},   strike_velocity, vel);
    check({tag, "_zone"},  strike_zone, zone);
    check({tag, "_count"}, strike_count, cnt);
    check({tag, "_state"}, state_dbg, 2);
    step(1);
    check({tag, "_one_cycle"}, strike_valid, 0);
  endtask

  task automatic wait_settle(output int n);
    n = 0;
    while (state_dbg !== 2'd3 && n < REFRACT + 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_refract(input string tag);
    int n;
    wait_settle(n);
    check({tag, "_settle"}, state_dbg, 3);
    gyro(16'sd0);
    check({tag, "_idle"}, state_dbg, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state_dbg, 0);
    check({tag, "_sv"},    strike_valid, 0);
    check({tag, "_ab"},    swing_abort, 0);
    check({tag, "_zone"},  strike_zone, 0);
    check({tag, "_vel"},   strike_velocity, 0);
    check({tag, "_count"}, strike_count, 0);
  endtask

  logic signed [15:0] zq_tab [6] = '{-16'sd8193, -16'sd8192, -16'sd1, 16'sd0, 16'sd8191, 16'sd8192};
  int                 zz_tab [6] = '{0, 1, 1, 2, 2, 3};

  initial begin
    int n;
    int sv0;
    int ab0;

    // Reset state.
    step(2);
    check_reset_outputs("rst");
    fpga_rst_n = 1'b1;
    enable = 1'b1;
    step(1);

    // Default qz of zero gives zone 2; 5000>>7 = 39.
    gyro(-16'sd5000);
    check("dflt_swing", state_dbg, 1);
    gyro(16'sd0);
    strike_check("dflt", 39, 2, 1);

    // Reset during REFRACT discards the event.
    sv0 = n_sv;
    fpga_rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_refract");
    step(1);
    fpga_rst_n = 1'b1;
    step(5);
    check("rst_refract_nopulse", n_sv, sv0);
    check("rst_refract_idle", state_dbg, 0);

    // Peak 20000 -> 156, qz 10000 -> zone 3.
    quat(16'sd10000);
    gyro(-16'sd5000);
    gyro(-16'sd12000);
    gyro(-16'sd20000);
    check("s1_swing", state_dbg, 1);
    gyro(-16'sd500);
    strike_check("s1", 156, 3, 1);

    // A swing during lockout is ignored; REFRACT lasts exactly REFRACT cycles.
    sv0 = n_sv;
    gyro(-16'sd9000);
    gyro(16'sd0);
    check("lock_state", state_dbg, 2);
    check("lock_count", strike_count, 1);
    check("lock_nopulse", n_sv, sv0);
    wait_settle(n);
    check("refract_len", n, REFRACT - 3);
    check("lock_settle", state_dbg, 3);
    gyro(16'sd0);
    check("lock_idle", state_dbg, 0);

    // Second swing after re-arm: 9000>>7 = 70.
    gyro(-16'sd9000);
    gyro(16'sd0);
    strike_check("s2", 70, 3, 2);
    finish_refract("s2");

    // Saturated magnitude 32767 -> 255.
    gyro(-16'sh8000);
    check("sat_swing", state_dbg, 1);
    gyro(16'sd0);
    strike_check("sat", 255, 3, 3);
    finish_refract("sat");

    // Quat update coinciding with the deciding sample does not affect the zone.
    quat(16'sd100);
    gyro(-16'sd8000);
    gyro_y = 16'sd0;
    gyro_valid = 1'b1;
    quat_z = -16'sd9000;
    quat_valid = 1'b1;
    @(negedge clk);
    gyro_valid = 1'b0;
    quat_valid = 1'b0;
    strike_check("qsame", 62, 2, 4);
    finish_refract("qsame");
    gyro(-16'sd8000);
    gyro(16'sd0);
    strike_check("qnext", 62, 0, 5);
    finish_refract("qnext");

    // Entry threshold: 3999 and positive rates do not start a swing.
    gyro(-16'sd3999);
    check("below_swing", state_dbg, 0);
    gyro(16'sd5000);
    check("positive_rate", state_dbg, 0);

    // Swing timeout after 64 samples.
    sv0 = n_sv;
    ab0 = n_ab;
    for (int i = 0; i < 63; i++) gyro(-16'sd6000);
    check("abort_pre_state", state_dbg, 1);
    check("abort_pre_cnt", n_ab, ab0);
    gyro(-16'sd6000);
    check("abort_pulse", swing_abort, 1);
    check("abort_state", state_dbg, 3);
    for (int i = 0; i < 6; i++) gyro(-16'sd6000);
    check("abort_hold_settle", state_dbg, 3);
    check("abort_once", n_ab, ab0 + 1);
    check("abort_nostrike", n_sv, sv0);
    check("abort_count", strike_count, 5);
    gyro(16'sd0);
    check("abort_idle", state_dbg, 0);

    // Zone boundaries; -1000 stays in SWING, -999 ends it; 4000>>7 = 31.
    for (int k = 0; k < 6; k++) begin
      quat(zq_tab[k]);
      gyro(-16'sd4000);
      check($sformatf("zb%0d_swing", k), state_dbg, 1);
      gyro(-16'sd1000);
      check($sformatf("zb%0d_hold", k), state_dbg, 1);
      gyro(-16'sd999);
      strike_check($sformatf("zb%0d", k), 31, zz_tab[k], 6 + k);
      finish_refract($sformatf("zb%0d", k));
    end

    // Dropping enable mid-swing returns to IDLE with no pulses; outputs hold.
    sv0 = n_sv;
    ab0 = n_ab;
    gyro(-16'sd7000);
    check("en_swing", state_dbg, 1);
    enable = 1'b0;
    step(1);
    check("en_idle", state_dbg, 0);
    gyro(16'sd0);
    gyro(-16'sd7000);
    step(2);
    check("en_stay_idle", state_dbg, 0);
    check("en_nostrike", n_sv, sv0);
    check("en_noabort", n_ab, ab0);
    check("en_count_hold", strike_count, 11);
    check("en_vel_hold", strike_velocity, 31);
    check("en_zone_hold", strike_zone, 3);
    enable = 1'b1;
    step(1);

    // Reset during SWING: no pulse after release.
    gyro(-16'sd7000);
    check("rsw_swing", state_dbg, 1);
    sv0 = n_sv;
    fpga_rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_swing");
    step(1);
    fpga_rst_n = 1'b1;
    gyro(16'sd0);
    step(2);
    check("rsw_nopulse", n_sv, sv0);
    check("rsw_idle", state_dbg, 0);
    check("rsw_count", strike_count, 0);

    check("no_overlap", n_overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/drum_strike_detector.md
DRUM_STRIKE_DETECTOR -- requirements
Module: drum_strike_detector

Interface
REQ-001 SHALL have parameter SWING_THRESH, default 4000: |gyro_y| at or above this value on a downward (negative) sample starts a swing.
REQ-002 SHALL have parameter STOP_THRESH, default 1000: |gyro_y| below this value ends a swing or settles the detector.
REQ-003 SHALL have parameter MAX_SWING_SAMPLES, default 64: number of gyro samples allowed in SWING before the swing is aborted.
REQ-004 SHALL have parameter REFRACT_CYCLES, default 150000: clk cycles of post-strike lockout (50 ms at 3 MHz).
REQ-005 SHALL have parameter ZONE_T, default 8192: quat_z boundary for zone classification.
REQ-006 SHALL have ports, in this order:
- clk  in  1  system clock, 3 MHz
- fpga_rst_n  in  1  asynchronous, active-low reset
- enable  in  1  sensor initialized; when low, detection is held off
- gyro_valid  in  1  one-cycle strobe; gyro_x/y/z valid
- gyro_x, gyro_y, gyro_z  in  16 signed each  angular rate
- quat_valid  in  1  one-cycle strobe; quat_w/x/y/z valid
- quat_w, quat_x, quat_y, quat_z  in  16 signed each  orientation
- strike_valid  out  1  one-cycle strike pulse
- strike_zone  out  2  zone latched at strike
- strike_velocity  out  8  peak swing rate latched at strike
- strike_count  out  16  total strikes, wraps
- swing_abort  out  1  one-cycle pulse on swing timeout
- state_dbg  out  2  current FSM state encoding

Function
REQ-007 SHALL implement FSM states IDLE=0, SWING=1, REFRACT=2, SETTLE=3.
REQ-008 SHALL evaluate gyro data only in cycles where gyro_valid=1; all other cycles SHALL leave the FSM unchanged, except for the REFRACT counter.
REQ-009 SHALL compute mag = |gyro_y|, saturating -32768 to 32767 as a 15-bit unsigned value.
REQ-010 IDLE->SWING SHALL occur on a sample with gyro_y<0 and mag>=SWING_THRESH. On entry: peak=mag, sample count=1.
REQ-011 In SWING, each sample with mag>=STOP_THRESH SHALL set peak=max(peak,mag) and increment the sample count.
REQ-012 In SWING, a sample with mag<STOP_THRESH SHALL declare a strike and move to REFRACT.
REQ-013 On a strike, in the cycle after the deciding sample:
- strike_valid=1 for exactly one cycle
- strike_velocity=peak[14:7]
- strike_zone=zone of the last latched quat_z
- strike_count incremented modulo 2^16
REQ-014 strike_velocity and strike_zone SHALL hold their values until the next strike.
REQ-015 In SWING, when the sample count reaches MAX_SWING_SAMPLES without a strike:
- pulse swing_abort for one cycle
- go to SETTLE
- no strike and no count change
REQ-016 REFRACT SHALL count REFRACT_CYCLES clk cycles from entry, ignoring gyro samples, then go to SETTLE.
REQ-017 SETTLE->IDLE SHALL occur on the first sample with mag<STOP_THRESH.
REQ-018 Zone SHALL be 0 if qz<-ZONE_T, 1 if -ZONE_T<=qz<0, 2 if 0<=qz<ZONE_T, and 3 if qz>=ZONE_T, where qz is the registered quat_z.
REQ-019 On each quat_valid, quat_z SHALL be registered. A quat update in the same cycle as a deciding gyro sample SHALL NOT affect that strike's zone.
REQ-020 Before any quat_valid after reset, the registered quat_z SHALL be 0, giving zone 2.
REQ-021 When enable=0:
- next state forced to IDLE synchronously
- no strike_valid or swing_abort pulses
- strike_count, strike_velocity and strike_zone hold
REQ-022 strike_valid and swing_abort SHALL never both be asserted in the same cycle.

Reset
REQ-023 On fpga_rst_n=0, asynchronously: state=IDLE, peak=0, sample count=0, refract counter=0, qz=0, strike_valid=0, swing_abort=0, strike_zone=0, strike_velocity=0, strike_count=0.
REQ-024 A reset asserted mid-swing or mid-refractory SHALL discard the in-progress event with no pulse on release.

Structure
REQ-025 SHALL place the state enum, zone type and default threshold constants in shared package drum_pkg.
REQ-026 SHALL use one sub-module, strike_zone_classifier: combinational qz to 2-bit zone per REQ-018.
REQ-027 SHALL keep the refract counter wide enough for REFRACT_CYCLES (18 bits at default).

Verification
REQ-028 Gyro_y samples -5000, -12000, -20000, -500 (enable=1, qz latched 10000): strike_valid one cycle after the -500 sample; velocity=156; zone=3; strike_count=1.
REQ-029 70 consecutive samples of gyro_y=-6000: swing_abort after the 64th sample, no strike; state SETTLE; IDLE after a sample of 0.
REQ-030 Strike, then a second swing of -9000 within 100000 cycles: no second strike. A swing after REFRACT and SETTLE completes produces strike_count=2.
REQ-031 gyro_y=-32768 then 0: velocity=255, with no overflow.
REQ-032 quat_valid (qz=-9000) in the same cycle as the deciding sample, previous qz=100: zone=2. The next strike uses zone=0.
REQ-033 fpga_rst_n pulsed low during SWING: all outputs at reset values, no pulse after release. enable=0 during SWING: IDLE next cycle, no pulses.
